spi_register_slave: RTL and testbench

SPI_REGISTER_SLAVE -- requirements
Module: spi_register_slave

---
 rtl/spi_register_slave_if.sv | 16 +
 rtl/spi_register_slave.sv | 153 +++++++++++++++
 tb/tb_spi_register_slave.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_register_slave_if.sv
// SPI pin bundle between an SPI master and spi_register_slave.
//   sclk    : SPI clock, mode 0 (master -> slave)
//   mosi    : master-out data, MSB first (master -> slave)
//   cs      : chip select, active-low (master -> slave)
//   miso    : slave-out data, MSB first (slave -> master)
//   miso_oe : miso output enable, high while selected (slave -> master)
interface spi_register_slave_if;
   logic sclk;
   logic mosi;
   logic cs;
   logic miso;
   logic miso_oe;

   modport master (output sclk, output mosi, output cs, input miso, input miso_oe);
   modport slave  (input sclk, input mosi, input cs, output miso, output miso_oe);
endinterface

// File: rtl/spi_register_slave.sv
// SPI mode-0 register-file slave. The first byte of a transaction is a command
// (bit7 = read, low bits = start address); every following byte writes or
// reads one register, with the address auto-incrementing and wrapping.
// All SPI pins are oversampled in the clock domain.
//   clock         : system clock
//   reset_n       : asynchronous active-low reset
//   spi           : SPI pins (slave modport)
//   register_0    : live contents of register 0
//   write_strobe  : one-cycle pulse on every register write
//   write_address : address of the last written register
//
// state   | meaning
// IDLE    | not selected, miso tri-stated (miso_oe = 0)
// COMMAND | shifting in the command byte, miso held at 0
// DATA    | transferring data bytes, write or read per latched R/W flag
module spi_register_slave #(
   parameter int         ADDRESS_WIDTH        = 4,
   parameter logic [7:0] REGISTER_RESET_VALUE = 8'h00
) (
   input  logic                     clock,
   input  logic                     reset_n,
   spi_register_slave_if.slave      spi,
   output logic [7:0]               register_0,
   output logic                     write_strobe,
   output logic [ADDRESS_WIDTH-1:0] write_address
);

   localparam int REG_COUNT = 2 ** ADDRESS_WIDTH;

   typedef enum logic [1:0] {IDLE, COMMAND, DATA} state_t;

   state_t                   state;
   logic [2:0]               sclk_sync;
   logic [2:0]               cs_sync;
   logic [1:0]               mosi_sync;
   logic [7:0]               rx_shift;
   logic [7:0]               tx_shift;
   logic [2:0]               bit_cnt;
   logic [ADDRESS_WIDTH-1:0] address;
   logic                     read_mode;
   logic                     tx_loaded;
   logic                     miso_oe_r;
   logic [7:0]               regs [REG_COUNT];

   logic                     sclk_rise;
   logic                     sclk_fall;
   logic                     cs_fall;
   logic                     cs_high;
   logic [7:0]               rx_next;
   logic [ADDRESS_WIDTH-1:0] cmd_address;
   logic [ADDRESS_WIDTH-1:0] address_inc;

   // Index 1 is the synchronized value, index 2 its previous sample for edges.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= 3'b000;
         cs_sync   <= 3'b111;
         mosi_sync <= 2'b00;
      end else begin
         sclk_sync <= {sclk_sync[1:0], spi.sclk};
         cs_sync   <= {cs_sync[1:0], spi.cs};
         mosi_sync <= {mosi_sync[0], spi.mosi};
      end
   end

   assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
   assign cs_fall     = ~cs_sync[1] & cs_sync[2];
   assign cs_high     = cs_sync[1];
   assign rx_next     = {rx_shift[6:0], mosi_sync[1]};
   assign cmd_address = rx_next[ADDRESS_WIDTH-1:0];
   assign address_inc = address + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         rx_shift      <= 8'h00;
         tx_shift      <= 8'h00;
         bit_cnt       <= 3'd0;
         address       <= '0;
         read_mode     <= 1'b0;
         tx_loaded     <= 1'b0;
         miso_oe_r     <= 1'b0;
         write_strobe  <= 1'b0;
         write_address <= '0;
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= REGISTER_RESET_VALUE;
      end else begin
         write_strobe <= 1'b0;
         // Deselect wins over everything, including a byte completing this cycle.
         if (cs_high) begin
            state     <= IDLE;
            miso_oe_r <= 1'b0;
            tx_shift  <= 8'h00;
            tx_loaded <= 1'b0;
            bit_cnt   <= 3'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     state     <= COMMAND;
                     miso_oe_r <= 1'b1;
                     bit_cnt   <= 3'd0;
                     rx_shift  <= 8'h00;
                     tx_shift  <= 8'h00;
                  end
               end
               COMMAND: begin
                  if (sclk_rise) begin
                     rx_shift <= rx_next;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        address   <= cmd_address;
                        read_mode <= rx_next[7];
                        state     <= DATA;
                        if (rx_next[7]) begin
                           tx_shift  <= regs[cmd_address];
                           tx_loaded <= 1'b1;
                        end
                     end
                  end
               end
               DATA: begin
                  if (sclk_rise) begin
                     rx_shift <= rx_next;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (!read_mode) begin
                           regs[address] <= rx_next;
                           write_strobe  <= 1'b1;
                           write_address <= address;
                        end else begin
                           tx_shift  <= regs[address_inc];
                           tx_loaded <= 1'b1;
                        end
                        address <= address_inc;
                     end
                  end else if (sclk_fall) begin
                     // The falling edge right after a load must keep the new MSB on miso.
                     if (tx_loaded) tx_loaded <= 1'b0;
                     else           tx_shift  <= {tx_shift[6:0], 1'b0};
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign spi.miso    = tx_shift[7] & miso_oe_r;
   assign spi.miso_oe = miso_oe_r;
   assign register_0  = regs[0];

endmodule

// File: tb/tb_spi_register_slave.sv
module tb_spi_register_slave;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] register_0;
   logic       write_strobe;
   logic [3:0] write_address;

   always #5 clock = ~clock;

   spi_register_slave_if bus();

   spi_register_slave #(.ADDRESS_WIDTH(4), .REGISTER_RESET_VALUE(8'h00)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .spi           (bus.slave),
      .register_0    (register_0),
      .write_strobe  (write_strobe),
      .write_address (write_address)
   );

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] model [16];
   wr_t        wr_q [$];
   logic [7:0] rd_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Half sclk period = 40 ns = 4 clock cycles, so sclk runs at clock/8.
   task automatic spi_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         bus.mosi = b[i];
         #40 bus.sclk = 1'b1;
         #40 bus.sclk = 1'b0;
      end
   endtask

   task automatic cs_begin();
      bus.cs = 1'b0;
      #40;
   endtask

   task automatic cs_end();
      #40 bus.cs = 1'b1;
      #80;
   endtask

   task automatic write_burst(input logic [3:0] addr, input logic [7:0] d[$]);
      wr_t        e;
      logic [7:0] cmd;
      cmd = {1'b0, 3'($urandom), addr};
      cs_begin();
      spi_bits(cmd, 8);
      for (int i = 0; i < d.size(); i++) begin
         e.addr = addr + 4'(i);
         e.data = d[i];
         model[e.addr] = d[i];
         wr_q.push_back(e);
         spi_bits(d[i], 8);
      end
      cs_end();
   endtask

   task automatic read_burst(input logic [3:0] addr, input int n);
      logic [3:0] a;
      logic [7:0] cmd;
      cmd = {1'b1, 3'($urandom), addr};
      cs_begin();
      spi_bits(cmd, 8);
      for (int i = 0; i < n; i++) begin
         a = addr + 4'(i);
         rd_q.push_back(model[a]);
         spi_bits(8'($urandom), 8);
      end
      cs_end();
   endtask

   // Write monitor: every strobe must match the next expected write.
   initial begin
      wr_t e;
      forever begin
         @(negedge clock);
         if (reset_n && write_strobe) begin
            if (wr_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_strobe: got address %0h expected no write at %0t", write_address, $time);
            end else begin
               e = wr_q.pop_front();
               check("write_address", 32'(write_address), 32'(e.addr));
               if (e.addr == 4'd0) begin
                  @(negedge clock);
                  check("register_0", 32'(register_0), 32'(e.data));
               end
            end
         end
      end
   end

   // Bus monitor: decodes the command from mosi, checks miso is 0 during the
   // command byte and compares every complete read byte with the expected queue.
   initial begin
      logic [7:0] mon_mosi;
      logic [7:0] mon_miso;
      int         mon_bits;
      bit         mon_data;
      bit         mon_read;
      mon_bits = 0;
      mon_data = 0;
      mon_read = 0;
      mon_mosi = 8'h00;
      mon_miso = 8'h00;
      forever begin
         @(posedge bus.sclk or posedge bus.cs or negedge reset_n);
         if (bus.cs || !reset_n) begin
            mon_bits = 0;
            mon_data = 0;
            mon_read = 0;
         end else if (bus.sclk) begin
            mon_mosi = {mon_mosi[6:0], bus.mosi};
            mon_miso = {mon_miso[6:0], bus.miso};
            mon_bits++;
            if (!mon_data) check("miso_during_cmd", 32'(bus.miso), 32'd0);
            if (mon_bits == 8) begin
               mon_bits = 0;
               if (!mon_data) begin
                  mon_data = 1;
                  mon_read = mon_mosi[7];
               end else if (mon_read) begin
                  if (rd_q.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL unexpected_read: got %0h expected nothing at %0t", mon_miso, $time);
                  end else begin
                     check("read_data", 32'(mon_miso), 32'(rd_q.pop_front()));
                  end
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] d[$];
      bus.cs   = 1'b1;
      bus.sclk = 1'b0;
      bus.mosi = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;

      // Reset state
      #20;
      check("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
      check("rst_miso", 32'(bus.miso), 32'd0);
      check("rst_write_strobe", 32'(write_strobe), 32'd0);
      check("rst_write_address", 32'(write_address), 32'd0);
      check("rst_register_0", 32'(register_0), 32'd0);
      reset_n = 1'b1;
      #40;

      // sclk activity without a cs falling edge is ignored
      spi_bits(8'h00, 8);
      spi_bits(8'hFF, 8);
      #40;
      check("idle_miso_oe", 32'(bus.miso_oe), 32'd0);

      // Single write, then read it back
      d = '{8'hA5};
      write_burst(4'd3, d);
      read_burst(4'd3, 1);

      // Register 0 write and read-back
      d = '{8'h5A};
      write_burst(4'd0, d);
      read_burst(4'd0, 1);

      // Burst that wraps from 15 to 0
      d = '{8'h11, 8'h22};
      write_burst(4'd15, d);
      read_burst(4'd15, 2);

      // Abort after 5 data bits leaves register 2 untouched
      d = '{8'h77};
      write_burst(4'd2, d);
      cs_begin();
      spi_bits(8'h02, 8);
      spi_bits(8'hC3, 5);
      cs_end();
      read_burst(4'd2, 1);

      // Reset in the middle of a read data byte
      cs_begin();
      spi_bits(8'h80, 8);
      spi_bits(8'h00, 3);
      #10 reset_n = 1'b0;
      #30;
      check("midrst_miso_oe", 32'(bus.miso_oe), 32'd0);
      check("midrst_miso", 32'(bus.miso), 32'd0);
      check("midrst_register_0", 32'(register_0), 32'd0);
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      #20 reset_n = 1'b1;
      #20 bus.cs = 1'b1;
      #100;
      read_burst(4'd0, 16);
      d = '{8'hC3};
      write_burst(4'd5, d);
      read_burst(4'd5, 1);

      // Random bursts at the minimum sclk ratio
      for (int t = 0; t < 10; t++) begin
         logic [3:0] a;
         int         n;
         a = 4'($urandom_range(0, 15));
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 1) begin
            d = {};
            for (int k = 0; k < n; k++) d.push_back(8'($urandom));
            write_burst(a, d);
         end else begin
            read_burst(a, n);
         end
      end
      read_burst(4'd0, 16);

      #200;
      check("pending_writes", 32'(wr_q.size()), 32'd0);
      check("pending_reads", 32'(rd_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
